// File: rtl/adder_result_fifo.sv
// Result-capture FIFO for a fixed-latency pipelined adder with no valid/stall signals.
// A valid shift line marks real operations, and issue credits guarantee every in-flight result a slot.
module adder_result_fifo #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         sum,
    input  logic                     cout,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_cout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     err_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      reserved_q, reserved_d;
    logic               err_q, err_d;
    logic [WIDTH:0]     mem [DEPTH];
    logic               issue, push, pop;

    // Credits cover buffered plus in-flight results, so this never depends on out_ready.
    assign in_ready  = rst_n && (reserved_q < CW'(DEPTH));
    assign issue     = in_valid && in_ready;
    assign push      = vld_q[LATENCY-1];
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign {out_cout, out_sum} = mem[rd_ptr_q];
    assign count     = count_q;
    assign err_drop  = err_q;

    always_comb begin
        vld_d      = {vld_q[LATENCY-2:0], issue};
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        reserved_d = reserved_q;
        err_d      = err_q || (in_valid && !in_ready);

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end

        if (issue && !pop) begin
            reserved_d = reserved_q + CW'(1);
        end else if (pop && !issue) begin
            reserved_d = reserved_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            reserved_q <= '0;
            err_q      <= 1'b0;
        end else begin
            vld_q      <= vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            reserved_q <= reserved_d;
            err_q      <= err_d;
        end
    end

    // Storage is intentionally not reset; count_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cout, sum};
        end
    end

`ifndef SYNTHESIS
    overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        (push && (count_q == CW'(DEPTH))) |-> pop);
`endif

endmodule

// File: tb/tb_adder_result_fifo.sv
// Bench for adder_result_fifo: behavioural adder pipe, queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_adder_result_fifo;

    localparam int LAT   = 4;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, cout, out_valid, out_ready, out_cout, err_drop;
    logic [31:0] sum, out_sum;
    logic [3:0]  count;
    logic [31:0] op_a, op_b;
    logic        op_ci;
    logic [32:0] pipe [LAT];

    always #5 clk = ~clk;

    adder_result_fifo #(.LATENCY(LAT), .DEPTH(DEPTH), .WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .count     (count),
        .err_drop  (err_drop)
    );

    // Stand-in for the 4-stage adder: always computes, knows nothing of validity.
    always @(posedge clk) begin
        pipe[0] <= {1'b0, op_a} + {1'b0, op_b} + {32'd0, op_ci};
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign sum  = pipe[LAT-1][31:0];
    assign cout = pipe[LAT-1][32];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [32:0] v;
        int          due;
    } fl_t;

    logic [32:0] exp_q[$];
    fl_t         fl_q[$];
    fl_t         item;
    logic        err_exp = 1'b0;
    logic        m_rdy;
    int          mc = 0;
    bit          chk_en = 0;

    // Inputs change only at negedge+1, so at negedge they still hold what the last edge sampled.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            fl_q.delete();
            err_exp = 1'b0;
            chk_en  = 1;
        end else begin
            m_rdy = (exp_q.size() + fl_q.size()) < DEPTH;
            if (in_valid && !m_rdy) err_exp = 1'b1;
            if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
            if (fl_q.size() != 0 && fl_q[0].due == mc) begin
                exp_q.push_back(fl_q[0].v);
                void'(fl_q.pop_front());
            end
            if (in_valid && m_rdy) begin
                item.v   = {1'b0, op_a} + {1'b0, op_b} + {32'd0, op_ci};
                item.due = mc + LAT;
                fl_q.push_back(item);
            end
        end
        mc++;
        if (chk_en) begin
            m_rdy = rst_n && ((exp_q.size() + fl_q.size()) < DEPTH);
            check("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("head", {out_cout, out_sum}, exp_q[0]);
            check("count", count, exp_q.size());
            check("in_ready", in_ready, m_rdy);
            check("err_drop", err_drop, err_exp);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic ordy);
        in_valid  = iv;
        out_ready = ordy;
        if (iv) begin
            op_a  = a;
            op_b  = b;
            op_ci = ci;
        end else begin
            op_a  = $urandom;
            op_b  = $urandom;
            op_ci = 1'($urandom);
        end
    endtask

    int k;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 4'd0);
        check("rst_err", err_drop, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Single op, cycle 0 is the cycle it is presented.
        drive(1'b1, 32'h0000FFFF, 32'h00000001, 1'b0, 1'b1);
        for (int c = 1; c <= 6; c++) begin
            tick();
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            if (c == 4) check("single_early", out_valid, 1'b0);
            if (c == 5) begin
                check("single_valid", out_valid, 1'b1);
                check("single_sum", out_sum, 32'h00010000);
                check("single_cout", out_cout, 1'b0);
                check("single_count", count, 4'd1);
            end
            if (c == 6) check("single_empty", count, 4'd0);
        end

        // Streaming: a=i, b=all-ones, cin=1 gives sum=i, cout=1.
        k = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            drive(c < 20, c, 32'hFFFFFFFF, 1'b1, 1'b1);
            if (c < 20) check("stream_ready", in_ready, 1'b1);
            if (c >= 5 && c < 25) check("stream_valid", out_valid, 1'b1);
            if (out_valid) begin
                check("stream_sum", out_sum, k);
                check("stream_cout", out_cout, 1'b1);
                k++;
            end
        end
        check("stream_total", k, 20);

        // Back-pressure with in_valid held high; drops start at cycle 8.
        for (int c = 0; c <= 12; c++) begin
            tick();
            drive(1'b1, 32'h1000 + c, c, 1'b0, 1'b0);
            if (c < 8) check("full_accept", in_ready, 1'b1);
            else check("full_block", in_ready, 1'b0);
            if (c == 9) check("drop_err", err_drop, 1'b1);
            if (c == 11) check("full_count11", count, 4'd7);
            if (c == 12) check("full_count12", count, 4'd8);
        end

        // Release, then one pop plus one issue per cycle across pointer wrap.
        for (int j = 0; j < 22; j++) begin
            tick();
            drive(1'b1, 32'h2000 + j, 32'd0, 1'b0, 1'b1);
            if (j == 0) begin
                check("release_block", in_ready, 1'b0);
                check("release_head0", out_sum, 32'h1000);
            end
            if (j == 1) begin
                check("release_ready", in_ready, 1'b1);
                check("release_head1", out_sum, 32'h1002);
            end
            check("wrap_bound", count <= 4'd8, 1'b1);
        end
        for (int j = 0; j < 14; j++) begin
            tick();
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        check("drain_count", count, 4'd0);
        check("drop_sticky", err_drop, 1'b1);

        // Reset mid-flight: three ops, reset for one edge two cycles after the last.
        for (int c = 0; c < 16; c++) begin
            tick();
            drive(c < 3, 32'h3000 + c, 32'd1, 1'b0, 1'b1);
            rst_n = (c != 4);
            #1;
            if (c == 4) check("rst_hold_ready", in_ready, 1'b0);
            if (c == 5) begin
                check("midrst_count", count, 4'd0);
                check("midrst_ready", in_ready, 1'b1);
                check("midrst_err", err_drop, 1'b0);
            end
            if (c >= 5) check("midrst_quiet", out_valid, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adder_result_fifo.md
# adder_result_fifo

Result-capture stage placed directly downstream of the 4-stage pipelined 32-bit adder. The adder has no valid or stall signals, so this block tracks which adder slots carry real operations with a latency-matched valid shift line. It captures the matching `sum`/`cout` into a small FIFO and presents results on a ready/valid interface. Credit-based issue control (`in_ready`) guarantees a result that is in flight always has a FIFO slot, so back-pressure never loses data.

## Interface
- `LATENCY`, 4: adder latency in cycles, from operands presented to `sum`/`cout` valid; must match the adder.
- `DEPTH`, 8: FIFO entries; power of 2, ≥ 2.
- `WIDTH`, 32: sum width.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  the upstream issuer is driving a real operation onto the adder's `a`/`b`/`cin` this cycle.
- `in_ready`  out  1  a credit is available; an operation is accepted only when `in_valid && in_ready`.
- `sum`  in  WIDTH  adder `sum` output.
- `cout`  in  1  adder `cout` output.
- `out_valid`  out  1  the FIFO head holds a result.
- `out_ready`  in  1  consumer accepts the head this cycle.
- `out_sum`  out  WIDTH  head result sum.
- `out_cout`  out  1  head result carry.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy (excludes in-flight results).
- `err_drop`  out  1  sticky: `in_valid` was seen while `in_ready` was 0.

## Operation
- **Issue.** `issue = in_valid && in_ready`.
- **Valid line.** `vld[LATENCY-1:0]` shifts `issue` in at `vld[0]` on every edge.
  - When `vld[LATENCY-1]` = 1, the current `sum`/`cout` belongs to an issued operation.
  - Write: `push = vld[LATENCY-1]`.
- **FIFO.**
  - Circular buffer with `wr_ptr`/`rd_ptr`, each `$clog2(DEPTH)` bits; both wrap from DEPTH-1 to 0.
  - `push` writes `{cout,sum}` at `wr_ptr`.
  - `pop = out_valid && out_ready` advances `rd_ptr`.
  - First-word fall-through: `out_sum`/`out_cout` = `mem[rd_ptr]`.
  - `out_valid = (count != 0)`.
  - Simultaneous push and pop: `count` is unchanged. This is legal when `count` = DEPTH because the credits reserve the slot.
- **Credits.**
  - `reserved` counts FIFO entries plus in-flight results; range 0..DEPTH.
  - Update rule: +1 on `issue`, −1 on `pop`, unchanged when both occur.
  - `in_ready = rst_n && (reserved < DEPTH)`.
  - By construction `push` never occurs with `count` = DEPTH unless `pop` occurs in the same cycle. A verification assertion must check this.
- **Error.**
  - `err_drop` sets when `in_valid && !in_ready` (outside reset). The operation is not tracked.
  - `err_drop` clears only on reset.
- **Reset** (`rst_n` low at an edge):
  - Cleared: `vld`, `wr_ptr`, `rd_ptr`, `count`, `reserved`, `err_drop`.
  - FIFO memory is not reset.
  - Outputs after reset: `out_valid`=0, `count`=0, `err_drop`=0, `in_ready`=1.
  - `in_ready`=0 while `rst_n` is low.
  - Reset mid-operation discards all in-flight and buffered results. Stale adder outputs are ignored because `vld` is cleared.

## Timing
- An operation issued in cycle n has its result on `sum`/`cout` during cycle n+LATENCY. The result is written at the edge ending that cycle.
- `out_valid` rises in cycle n+LATENCY+1 if the FIFO was empty, giving issue-to-out_valid latency of LATENCY+1 = 5.
- Pop takes effect at the edge. The next head appears in the following cycle.
- Sustained throughput is 1 result/cycle when `out_ready` is held at 1.
- `in_ready` is combinational from `reserved` only, never from `in_valid` or `out_ready`. It can rise the cycle after a pop.
- With `out_ready` stuck at 0, at most DEPTH operations are accepted. `in_ready` falls in the cycle after the DEPTH-th issue.

## Test plan
- **Single op.**
  - Stimulus: after reset, issue a=32'h0000FFFF, b=32'h00000001, cin=0 in cycle 0.
  - Response: `out_valid`=1 in cycle 5 with `out_sum`=32'h00010000, `out_cout`=0; pop empties the FIFO, `count` returns to 0.
- **Streaming.**
  - Stimulus: issue 20 back-to-back ops (a=i, b=32'hFFFFFFFF, cin=1) with `out_ready`=1.
  - Response: results appear in order on consecutive cycles; `out_sum`=i, `out_cout`=1 for every op; `in_ready` never drops.
- **Full / back-pressure.**
  - Stimulus: `out_ready`=0, `in_valid` held at 1.
  - Response: exactly 8 ops accepted; `in_ready`=0 from the cycle after the 8th issue; `count` reaches 8 in cycle 12.
  - Then set `out_ready`=1: one pop per cycle; `in_ready` returns to 1 the cycle after the first pop.
- **Wrap-around / simultaneous.**
  - Stimulus: with `count`=8 and credits exhausted, pop one entry and issue one new op per cycle for 20 cycles.
  - Response: `count` remains at or below 8, data stays in order, pointers wrap correctly, no overflow assertion fires.
- **Drop error.**
  - Stimulus: drive `in_valid`=1 while `in_ready`=0.
  - Response: `err_drop`=1 next cycle and stays set; no extra result is ever pushed.
- **Reset mid-flight.**
  - Stimulus: issue 3 ops, assert `rst_n`=0 for one edge two cycles later.
  - Response: `out_valid` stays 0 afterwards, `count`=0, `in_ready`=1, `err_drop`=0.
